// File: rtl/mips_cpu_instr_memory.sv
// mips_cpu_instr_memory
//   Instruction-side responder for mips_cpu_harvard. It holds a word RAM that
//   is mapped at BASE_ADDR, which is the reset vector. A byte-serial
//   valid/ready loader fills the RAM at the start of a run. The CPU fetch path
//   is combinational: an illegal fetch returns a NOP and sets a sticky fault.
//
//   Parameters
//     BASE_ADDR    byte address of word 0 (default 32'hBFC00000)
//     DEPTH        RAM size in 32-bit words; a power of two, 4..4096
//
//   Ports
//     clk, reset      rising-edge clock; synchronous active-high reset
//     clk_enable      low freezes all state and blocks handshakes
//     instr_address   CPU fetch byte address
//     instr_readdata  fetched word in the CPU's byte-reversed bus order
//     load_valid / load_byte / load_last / load_ready
//                     loader stream; bytes arrive in big-endian memory order
//     load_restart    when DONE, restart loading at word 0
//     loaded          image complete; fetches are served
//     fetch_fault     sticky flag for an illegal fetch
//     fetch_count     served-fetch counter
//
//   Optional feature
//     MIPS_IMEM_FETCH_COUNT_EN  when defined, fetch_count counts valid fetches.
//                               When undefined, fetch_count is tied to 0.

module mips_cpu_instr_memory #(
    parameter logic [31:0] BASE_ADDR = 32'hBFC00000,
    parameter int          DEPTH     = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic [31:0] instr_address,
    output logic [31:0] instr_readdata,
    input  logic        load_valid,
    input  logic [7:0]  load_byte,
    input  logic        load_last,
    output logic        load_ready,
    input  logic        load_restart,
    output logic        loaded,
    output logic        fetch_fault,
    output logic [31:0] fetch_count
);

    localparam int          AW   = $clog2(DEPTH);
    localparam logic [31:0] SPAN = 32'(4 * DEPTH);

    typedef enum logic {S_LOADING, S_DONE} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] wr_ptr;
    logic [1:0]    phase;
    logic [23:0]   hold;        // bytes b0..b2 of the word in progress; b0 is in [7:0]
    logic [31:0]   wr_word;
    logic [31:0]   mem [DEPTH];
    logic          accept, word_done, restart;
    logic [31:0]   offset;
    logic          fetch_valid, fetch_zero;

    assign load_ready = (state == S_LOADING) && clk_enable && !reset;
    assign accept     = load_valid && load_ready;
    assign word_done  = accept && ((phase == 2'd3) || load_last);
    assign restart    = (state == S_DONE) && clk_enable && load_restart;
    assign loaded     = (state == S_DONE);

    // Build {b3,b2,b1,b0}. Bytes after the current phase are zero padding,
    // which covers an early load_last.
    always_comb begin
        wr_word = 32'h0;
        case (phase)
            2'd0: wr_word = {24'h0, load_byte};
            2'd1: wr_word = {16'h0, load_byte, hold[7:0]};
            2'd2: wr_word = {8'h0, load_byte, hold[15:0]};
            2'd3: wr_word = {load_byte, hold[23:0]};
            default: wr_word = 32'h0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_LOADING: if (word_done && (load_last || wr_ptr == AW'(DEPTH - 1)))
                           state_nxt = S_DONE;
            S_DONE:    if (restart)
                           state_nxt = S_LOADING;
            default:   state_nxt = S_LOADING;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_LOADING;
            wr_ptr      <= '0;
            phase       <= 2'd0;
            hold        <= 24'h0;
            fetch_fault <= 1'b0;
        end else begin
            state <= state_nxt;
            if (restart) begin
                wr_ptr      <= '0;
                phase       <= 2'd0;
                fetch_fault <= 1'b0;
            end else begin
                if (accept) begin
                    if (word_done) begin
                        phase <= 2'd0;
                        if (state_nxt == S_LOADING)
                            wr_ptr <= wr_ptr + 1'b1;
                    end else begin
                        hold[{phase, 3'b000} +: 8] <= load_byte;
                        phase <= phase + 2'd1;
                    end
                end
                if (clk_enable && loaded && !fetch_valid && !fetch_zero)
                    fetch_fault <= 1'b1;
            end
        end
    end

    // The RAM has no reset. Its contents survive a reset or a restart until
    // they are overwritten.
    always_ff @(posedge clk) begin
        if (word_done)
            mem[wr_ptr] <= wr_word;
    end

    // Combinational fetch. Address 0 is the CPU halt target: it reads as a NOP
    // and never raises a fault.
    assign fetch_zero  = (instr_address == 32'h0);
    assign offset      = instr_address - BASE_ADDR;
    assign fetch_valid = loaded && !fetch_zero && (instr_address[1:0] == 2'b00) &&
                         (instr_address >= BASE_ADDR) && (offset < SPAN);
    assign instr_readdata = fetch_valid ? mem[offset[AW+1:2]] : 32'h0;

`ifdef MIPS_IMEM_FETCH_COUNT_EN
    logic [31:0] count_q;
    always_ff @(posedge clk) begin
        if (reset)
            count_q <= 32'h0;
        else if (restart)
            count_q <= 32'h0;
        else if (clk_enable && fetch_valid && count_q != 32'hFFFF_FFFF)
            count_q <= count_q + 32'd1;
    end
    assign fetch_count = count_q;
`else
    assign fetch_count = 32'h0;
`endif

endmodule
